// File: rtl/message_slicer_stream.sv
// Circular-buffer slicer: accepts wide words of up to N_SLICES slices and emits them
// one WIDTH-bit slice at a time through a registered ready/valid output stage.
module message_slicer_stream #(
  parameter int unsigned N_SLICES          = 2,
  parameter int unsigned LOG_N_SLICES      = 1,
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned BUFFER_LENGTH     = 64,
  parameter int unsigned LOG_BUFFER_LENGTH = 6,
  parameter bit          MSB_FIRST         = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [WIDTH*N_SLICES-1:0]     in_data,
  input  logic [LOG_N_SLICES:0]         in_count,
  input  logic                          in_nd,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_nd,
  input  logic                          out_ready,
  output logic [LOG_BUFFER_LENGTH:0]    count,
  output logic                          error
);

  localparam int unsigned CW = LOG_N_SLICES + 1;
  localparam int unsigned PW = LOG_BUFFER_LENGTH;
  localparam int unsigned NW = LOG_BUFFER_LENGTH + 1;
  localparam logic [CW-1:0] MAX_COUNT = CW'(N_SLICES);
  localparam logic [NW-1:0] DEPTH     = NW'(BUFFER_LENGTH);
  localparam logic [NW-1:0] THRESH    = NW'(N_SLICES);

  logic [WIDTH-1:0] mem [BUFFER_LENGTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             count_ok;
  logic             do_write;
  logic             do_pop;
  logic             bad_word;
  logic [NW-1:0]    n_add;
  logic [NW-1:0]    n_sub;

  // in_ready looks only at current occupancy, so a same-cycle pop never frees room early.
  always_comb begin
    in_ready = (DEPTH - count) >= THRESH;
    count_ok = in_count <= MAX_COUNT;
    do_write = in_nd & in_ready & count_ok & ~clear;
    bad_word = in_nd & ~(in_ready & count_ok);
    do_pop   = (~out_nd | out_ready) & (count != '0) & ~clear;
    n_add    = do_write ? NW'(in_count) : '0;
    n_sub    = do_pop ? NW'(1) : '0;
  end

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned j = 0; j < N_SLICES; j++) begin
        if (CW'(j) < in_count) begin
          mem[wr_ptr + PW'(j)] <= MSB_FIRST ? in_data[(N_SLICES-1-j)*WIDTH +: WIDTH]
                                            : in_data[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
      out_nd   <= 1'b0;
      error    <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out_nd <= 1'b0;
      error  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PW'(in_count);
      if (bad_word) error <= 1'b1;
      count <= count + n_add - n_sub;
      if (do_pop) begin
        out_data <= mem[rd_ptr];
        out_nd   <= 1'b1;
        rd_ptr   <= rd_ptr + PW'(1);
      end else if (out_ready) begin
        out_nd <= 1'b0;
      end
    end
  end

endmodule
